wrr_burst_arbiter: RTL
======================

Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter sharing one beat-oriented resource (bus/port) between N requesters.
- Each grant is a burst of up to weight[i] accepted beats. Weights are runtime-programmable.
- Sits between requester clients and the shared resource, and replaces a plain round-robin arbiter where bandwidth shares must differ per client.

Parameters:
- N, 4, number of requesters (2..16).
- WW, 4, weight/credit width in bits.
- DEFAULT_WEIGHT, 1, reset value of every weight register.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-high reset (asserted = 1).
- request  input  N  per-requester request, level, held while wanting service.
- resource_ready  input  1  resource accepts a beat this cycle.
- cfg_we  input  1  weight write strobe.
- cfg_idx  input  $clog2(N)  weight register index.
- cfg_weight  input  WW  weight value to write.
- grant  output  N  registered one-hot grant; all zero when idle.
- grant_valid  output  1  OR of grant.
- grant_idx  output  $clog2(N)  index of the granted requester; 0 when idle.
- beat  output  1  grant_valid & resource_ready & request[grant_idx]; a beat is consumed.

Behaviour:
- Reset values:
  - grant=0, grant_valid=0, grant_idx=0.
  - ptr=0, credit=0, state=IDLE.
  - all weight[i]=DEFAULT_WEIGHT.
- Eligibility: requester i is eligible iff request[i]=1 and weight[i]!=0. Weight 0 masks the requester permanently until it is rewritten.
- Pick rule: the first eligible index scanning ptr, ptr+1, ..., ptr+N-1 (mod N).
- States:
  - IDLE: if any requester is eligible, register the pick into grant/grant_idx, load credit=weight[pick], and go to GRANT. Grant is visible the cycle after request is first sampled (1-cycle latency).
  - GRANT, per cycle with beat=1: credit decrements.
  - GRANT, release condition: (beat=1 and credit==1) or request[grant_idx]=0.
  - GRANT, on release: ptr <= grant_idx+1 (mod N), and re-pick in the same cycle using the updated ptr.
    - If a requester is eligible, load the new grant and credit next cycle, with no bubble.
    - Otherwise grant=0 next cycle and go to IDLE.
  - GRANT, otherwise: hold grant. resource_ready low simply stalls; credit does not change.
- Repeat grants: a lone requester whose credit is exhausted is re-granted back-to-back with fresh credit.
- Weight writes: a write with cfg_idx<N updates weight[cfg_idx] at the next edge; cfg_idx>=N is ignored.
- Writes mid-burst: do not alter the live credit; the new weight applies at the next grant of that index.
- Same-cycle write and pick: a write in the same cycle as a pick of that index loads the OLD weight.
- Request drop: if request[grant_idx] drops, release in that cycle; beat=0 because the request is low.
- Reset mid-burst: outputs clear asynchronously; after release, the first pick starts from ptr=0.
- Credit width: credit register is WW bits; weight 2^WW-1 is the maximum burst.

Optional Feature:
- Macro: WRR_LOCK_EN.
- When defined: adds input `lock` (1 bit). While lock=1 and request[grant_idx]=1, credit exhaustion does not release the grant; credit saturates at 0, and beats continue.
  - Release occurs when lock=0 with credit==0 (next cycle) or on request drop.
  - lock is ignored in IDLE.
- When undefined: no port; behaviour exactly as above.

Decomposition:
- Package wrr_arb_pkg:
  - state enum {IDLE, GRANT}.
  - helper function for mod-N increment.
  - localparam IDXW=$clog2(N) pattern.
- Sub-module rr_pick: combinational; inputs eligible[N] and ptr; outputs one-hot pick, pick_idx, any. It is instantiated once and shared by the IDLE and release paths.

Test Plan:
- Reset, then request=4'b0001, resource_ready=1, all weights 1 -> grant=0001 one cycle later. Grant is re-issued each cycle (back-to-back) with beat=1 every cycle.
- weights {1,2,3,4}, request=4'b1111, ready=1 -> grant sequence 0001 x1, 0010 x2, 0100 x3, 1000 x4, then repeats; no idle cycles.
- weight[1]=2, request=4'b0010, resource_ready toggling 1,0,1 -> grant held 3 cycles, and exactly 2 beats occur before ptr advances.
- Request drop: during grant 0100 with credit 3 remaining, drop request[2] -> grant moves to the next eligible requester (or 0) the next cycle, and ptr=3.
- Weight writes: cfg write weight[3]=0 with request=4'b1001 -> only requester 0 is granted. Rewrite weight[3]=2 mid-burst of requester 0 -> requester 3 gets 2 beats on its next turn.
- Reset mid-burst: assert rst_n mid-burst -> grant=0 immediately (async). After release with request=4'b1111, first grant=0001 and all weights equal DEFAULT_WEIGHT.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
// -----------------------------------------------------------------------------
// wrr_arb_pkg
// Shared types and helpers for the weighted round-robin burst arbiter.
//   arb_state_e : arbiter FSM state (IDLE = no live grant, GRANT = burst live)
//   wrap_inc    : modulo-n increment used to advance the round-robin pointer
// -----------------------------------------------------------------------------
package wrr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Increment v and wrap to 0 once it reaches n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first eligible requester when
// scanning ptr, ptr+1, ..., ptr+N-1 (mod N).
// Ports:
//   eligible [N]    : per-requester eligibility
//   ptr      [IDXW] : scan start index
//   pick     [N]    : one-hot winner, zero when nothing is eligible
//   pick_idx [IDXW] : index of the winner, zero when nothing is eligible
//   any             : at least one requester is eligible
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    pick,
    output logic [IDXW-1:0] pick_idx,
    output logic            any
);

    always_comb begin
        int j;
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract is a full modulo
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && eligible[j]) begin
                any      = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_burst_arbiter
// Weighted round-robin arbiter for one beat-oriented shared resource. Each
// grant is a burst of up to weight[i] accepted beats; weights are programmable
// at run time through a small write port.
//
// Optional feature (macro WRR_LOCK_EN): adds input 'lock'. While lock is high
// and the granted requester keeps requesting, credit exhaustion does not end
// the burst (credit saturates at zero and beats continue).
//
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous reset, active HIGH despite the name
//   lock           : (WRR_LOCK_EN only) hold the current grant past its credit
//   request [N]    : level requests, held while the client wants service
//   resource_ready : resource accepts a beat this cycle
//   cfg_we         : weight write strobe
//   cfg_idx        : weight register index (writes with cfg_idx >= N ignored)
//   cfg_weight     : weight value; 0 masks that requester
//   grant [N]      : registered one-hot grant, zero when idle
//   grant_valid    : OR of grant
//   grant_idx      : index of granted requester, zero when idle
//   beat           : a beat is transferred this cycle
// -----------------------------------------------------------------------------
module wrr_burst_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N              = 4,
    parameter int WW             = 4,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef WRR_LOCK_EN
    input  logic                 lock,
`endif
    input  logic [N-1:0]         request,
    input  logic                 resource_ready,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_idx,
    input  logic [WW-1:0]        cfg_weight,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 beat
);

    localparam int IDXW = $clog2(N);

    arb_state_e      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [WW-1:0]   credit_q, credit_d;
    logic [WW-1:0]   weight_q [N];

    logic [N-1:0]    eligible;
    logic [IDXW-1:0] next_ptr;
    logic [IDXW-1:0] pick_ptr;
    logic [N-1:0]    pick;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            req_live;
    logic            release_grant;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eligible[i] = request[i] && (weight_q[i] != '0);
        end
    end

    assign req_live    = request[grant_idx_q];
    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = grant_idx_q;
    assign beat        = grant_valid & resource_ready & req_live;

    // On release the pointer moves past the current holder; the re-pick in the
    // same cycle must already use that advanced pointer so bursts chain with
    // no bubble. In IDLE the stored pointer is used directly.
    assign next_ptr = IDXW'(wrap_inc(32'(grant_idx_q), N));
    assign pick_ptr = (state_q == GRANT) ? next_ptr : ptr_q;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        credit_d      = credit_q;
        release_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d     = pick;
                    grant_idx_d = pick_idx;
                    credit_d    = weight_q[pick_idx];
                    state_d     = GRANT;
                end
            end

            GRANT: begin
                if (beat) begin
`ifdef WRR_LOCK_EN
                    if (credit_q != '0) begin
                        credit_d = credit_q - WW'(1);
                    end
`else
                    credit_d = credit_q - WW'(1);
`endif
                end

`ifdef WRR_LOCK_EN
                // Locked bursts keep going at zero credit; once lock drops
                // a burst sitting at zero credit ends immediately.
                release_grant = !req_live ||
                                (!lock && ((beat && (credit_q == WW'(1))) ||
                                           (credit_q == '0)));
`else
                release_grant = !req_live || (beat && (credit_q == WW'(1)));
`endif

                if (release_grant) begin
                    ptr_d = next_ptr;
                    if (pick_any) begin
                        grant_d     = pick;
                        grant_idx_d = pick_idx;
                        credit_d    = weight_q[pick_idx];
                    end else begin
                        grant_d     = '0;
                        grant_idx_d = '0;
                        credit_d    = '0;
                        state_d     = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            credit_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
        end
    end

    // Weight registers are read combinationally by the picker, so a write in
    // the same cycle as a pick of that index loads the old value. Live credit
    // is never touched by a write.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                weight_q[i] <= WW'(DEFAULT_WEIGHT);
            end
        end else if (cfg_we && (32'(cfg_idx) < N)) begin
            weight_q[cfg_idx] <= cfg_weight;
        end
    end

endmodule
